// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side drain engine for an asynchronous FIFO.
// Runs in the read clock domain only. It pops the FIFO with rinc and captures
// the registered rdata one cycle later into a 3-entry buffer. It re-presents
// the words as a valid/ready stream at one word per cycle. rinc depends only
// on registers, rempty and rrstn, so out_ready has no combinational path to it.
//
// Ports:
//   rclk      - read-domain clock
//   rrstn     - async active-low reset (shared with FIFO read domain)
//   rempty    - FIFO empty flag
//   rdata     - FIFO read data, valid the cycle after an accepted pop
//   rinc      - FIFO pop request
//   out_valid - stream word available
//   out_ready - downstream accepts the word
//   out_data  - stream word
//   buf_cnt   - buffer occupancy 0..3
module fifo_rd_streamer #(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       buf_cnt
);

  logic [WIDTH-1:0] mem [0:2];
  logic [1:0]       wr_ptr, rd_ptr, cnt;
  logic             inflight;
  logic             pop;
  logic [2:0]       credit;

  // Pointers cycle 0->1->2->0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word popped now lands one cycle later; counting it as occupied reserves
  // its slot without relying on any downstream pop.
  assign credit    = {1'b0, cnt} + {2'b00, inflight};
  assign rinc      = rrstn & ~rempty & (credit <= 3'd2);
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];
  assign buf_cnt   = cnt;

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // With cnt=1 a simultaneous write and pop hit different slots, so no bypass.
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
